// File: rtl/control_barrido_display.sv
// Scan controller for a 4-digit 7-segment display. It drives one shared cathode bus and one
// active-low anode per digit, blanks between digits, and swaps patterns only at frame edges.
module control_barrido_display #(
  parameter int unsigned DIV_MAX   = 50000,
  parameter int unsigned BLANK_CYC = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       cargar,
  input  logic [7:0] catodo1,
  input  logic [7:0] catodo2,
  input  logic [7:0] catodo3,
  input  logic [7:0] catodo4,
  output logic [3:0] anodo,
  output logic [7:0] catodo,
  output logic [1:0] digito,
  output logic       listo
);

  localparam int unsigned   CW         = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DIV_MAX - 1);
  // Only consulted when BLANK_CYC > 0; otherwise the BLANK state is never entered.
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);
  localparam logic [7:0]    PAT_ZERO   = 8'b00000011;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_ON    = 2'd2;

  localparam logic [1:0] ST_SLOT_START = (BLANK_CYC == 0) ? ST_ON : ST_BLANK;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    dig_q, dig_d;
  logic          pend_q, pend_d;
  logic [7:0]    staging_q [4];
  logic [7:0]    staging_d [4];
  logic [7:0]    shadow_q [4];
  logic [7:0]    shadow_d [4];
  logic          xfer;
  logic [3:0]    anodo_d;
  logic [7:0]    catodo_d;
  logic          listo_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dig_d     = dig_q;
    pend_d    = pend_q;
    staging_d = staging_q;
    shadow_d  = shadow_q;
    xfer      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        dig_d = 2'd0;
        // Nothing is on screen, so pending patterns can be taken at once.
        xfer  = pend_q;
        if (enable) begin
          state_d = ST_SLOT_START;
        end
      end
      ST_BLANK: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dig_d   = 2'd0;
        end else begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == BLANK_LAST) begin
            state_d = ST_ON;
          end
        end
      end
      ST_ON: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
          dig_d   = 2'd0;
        end else if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          dig_d   = dig_q + 2'd1;
          state_d = ST_SLOT_START;
          xfer    = (dig_q == 2'd3) && pend_q;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        dig_d   = 2'd0;
      end
    endcase

    listo_d = xfer;
    if (xfer) begin
      shadow_d = staging_q;
      pend_d   = 1'b0;
    end
    // A load in the transfer cycle is staged for the next boundary.
    if (cargar) begin
      staging_d[0] = catodo1;
      staging_d[1] = catodo2;
      staging_d[2] = catodo3;
      staging_d[3] = catodo4;
      pend_d       = 1'b1;
    end
  end

  // Outputs are decoded from next-state values so they line up with the registered state.
  always_comb begin
    anodo_d  = 4'b1111;
    catodo_d = 8'hFF;
    if (state_d == ST_ON) begin
      anodo_d  = ~(4'b0001 << dig_d);
      catodo_d = shadow_d[dig_d];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dig_q   <= 2'd0;
      pend_q  <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        staging_q[i] <= PAT_ZERO;
        shadow_q[i]  <= PAT_ZERO;
      end
      anodo   <= 4'b1111;
      catodo  <= 8'hFF;
      digito  <= 2'd0;
      listo   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dig_q     <= dig_d;
      pend_q    <= pend_d;
      staging_q <= staging_d;
      shadow_q  <= shadow_d;
      anodo     <= anodo_d;
      catodo    <= catodo_d;
      digito    <= dig_d;
      listo     <= listo_d;
    end
  end

endmodule

// File: tb/tb_control_barrido_display.sv
// Directed bench for control_barrido_display with DIV_MAX=8, BLANK_CYC=2 plus a BLANK_CYC=0 copy.
module tb_control_barrido_display;

  logic       clk = 1'b0;
  logic       reset, enable, cargar;
  logic [7:0] catodo1, catodo2, catodo3, catodo4;
  logic [3:0] anodo, anodo0;
  logic [7:0] catodo, catodo0;
  logic [1:0] digito, digito0;
  logic       listo, listo0;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [31:0] ZEROS = {4{8'h03}};

  always #5 clk = ~clk;

  control_barrido_display #(.DIV_MAX(8), .BLANK_CYC(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .cargar(cargar),
    .catodo1(catodo1), .catodo2(catodo2), .catodo3(catodo3), .catodo4(catodo4),
    .anodo(anodo), .catodo(catodo), .digito(digito), .listo(listo)
  );

  control_barrido_display #(.DIV_MAX(8), .BLANK_CYC(0)) dut0 (
    .clk(clk), .reset(reset), .enable(enable), .cargar(cargar),
    .catodo1(catodo1), .catodo2(catodo2), .catodo3(catodo3), .catodo4(catodo4),
    .anodo(anodo0), .catodo(catodo0), .digito(digito0), .listo(listo0)
  );

  // k counts cycles since the scan started: 8-cycle slots, first 2 blank.
  function automatic logic [3:0] exp_an(int k);
    if (k % 8 < 2) return 4'hF;
    return ~(4'b0001 << ((k / 8) % 4));
  endfunction

  function automatic logic [7:0] exp_cat(int k, logic [31:0] pats);
    if (k % 8 < 2) return 8'hFF;
    return pats[8 * ((k / 8) % 4) +: 8];
  endfunction

  function automatic logic [1:0] exp_dig(int k);
    return 2'((k / 8) % 4);
  endfunction

  task automatic do_reset(input logic en);
    @(negedge clk);
    reset = 1'b1; enable = 1'b0; cargar = 1'b0;
    catodo1 = 8'h03; catodo2 = 8'h03; catodo3 = 8'h03; catodo4 = 8'h03;
    @(negedge clk);
    reset = 1'b0; enable = en;
  endtask

  task automatic test_reset;
    @(negedge clk);
    reset = 1'b1; enable = 1'b1; cargar = 1'b0;
    catodo1 = 8'h03; catodo2 = 8'h03; catodo3 = 8'h03; catodo4 = 8'h03;
    @(negedge clk);
    n_cmp++;
    if ({anodo, catodo, digito, listo} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
      n_bad++;
      $display("FAIL reset_state: got %h/%h/%0d/%b want f/ff/0/0", anodo, catodo, digito, listo);
    end
    reset = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({anodo, catodo, digito, listo} !== {exp_an(k), exp_cat(k, ZEROS), exp_dig(k), 1'b0})
      begin
        n_bad++;
        $display("FAIL scan k=%0d: got %h/%h/%0d/%b want %h/%h/%0d/0", k, anodo, catodo, digito,
                 listo, exp_an(k), exp_cat(k, ZEROS), exp_dig(k));
      end
      n_cmp++;
      if ($countones(~anodo) > 1) begin
        n_bad++;
        $display("FAIL onehot k=%0d: got anodo=%b want at most one 0", k, anodo);
      end
    end
  endtask

  task automatic test_load;
    logic [31:0] pats;
    int          pulses;
    pats   = {8'h49, 8'h99, 8'h25, 8'h9F};
    pulses = 0;
    do_reset(1'b1);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({anodo, catodo, digito} !== {exp_an(k), exp_cat(k, (k < 32) ? ZEROS : pats), exp_dig(k)}
          || listo !== (k == 32)) begin
        n_bad++;
        $display("FAIL load k=%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", k, anodo, catodo, digito,
                 listo, exp_an(k), exp_cat(k, (k < 32) ? ZEROS : pats), exp_dig(k), k == 32);
      end
      if (listo === 1'b1) pulses++;
      if (k == 10) begin
        cargar = 1'b1;
        catodo1 = 8'h9F; catodo2 = 8'h25; catodo3 = 8'h99; catodo4 = 8'h49;
      end
      if (k == 11) cargar = 1'b0;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL load_listo_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_double_load;
    logic [31:0] pats;
    int          pulses;
    pats   = {8'h03, 8'h03, 8'h03, 8'h0D};
    pulses = 0;
    do_reset(1'b1);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      n_cmp++;
      if ({anodo, catodo, digito} !== {exp_an(k), exp_cat(k, (k < 32) ? ZEROS : pats), exp_dig(k)}
          || listo !== (k == 32)) begin
        n_bad++;
        $display("FAIL double_load k=%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", k, anodo, catodo,
                 digito, listo, exp_an(k), exp_cat(k, (k < 32) ? ZEROS : pats), exp_dig(k),
                 k == 32);
      end
      if (listo === 1'b1) pulses++;
      if (k == 3) begin cargar = 1'b1; catodo1 = 8'h9F; end
      if (k == 4) cargar = 1'b0;
      if (k == 20) begin cargar = 1'b1; catodo1 = 8'h0D; end
      if (k == 21) cargar = 1'b0;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL double_load_listo_count: got %0d want 1", pulses);
    end
  endtask

  task automatic test_back_to_back;
    logic [31:0] pa, pb, pe;
    pa = {8'h03, 8'h03, 8'h03, 8'h9F};
    pb = {8'h03, 8'h03, 8'h03, 8'h25};
    do_reset(1'b1);
    for (int k = 0; k < 72; k++) begin
      @(negedge clk);
      pe = (k < 32) ? ZEROS : (k < 64) ? pa : pb;
      n_cmp++;
      if ({anodo, catodo, digito} !== {exp_an(k), exp_cat(k, pe), exp_dig(k)}
          || listo !== (k == 32 || k == 64)) begin
        n_bad++;
        $display("FAIL back_to_back k=%0d: got %h/%h/%0d/%b want %h/%h/%0d/%b", k, anodo, catodo,
                 digito, listo, exp_an(k), exp_cat(k, pe), exp_dig(k), k == 32 || k == 64);
      end
      if (k == 5) begin cargar = 1'b1; catodo1 = 8'h9F; end
      if (k == 6) cargar = 1'b0;
      // Loaded in the very cycle of the frame-boundary transfer.
      if (k == 31) begin cargar = 1'b1; catodo1 = 8'h25; end
      if (k == 32) cargar = 1'b0;
    end
  endtask

  task automatic test_idle_load;
    logic want;
    do_reset(1'b0);
    cargar = 1'b1; catodo1 = 8'h0D;
    for (int n = 1; n <= 3; n++) begin
      @(negedge clk);
      cargar = 1'b0;
      want = (n == 2);
      n_cmp++;
      if ({anodo, listo} !== {4'hF, want}) begin
        n_bad++;
        $display("FAIL idle_load n=%0d: got anodo=%h listo=%b want f/%b", n, anodo, listo, want);
      end
    end
    enable = 1'b1;
    for (int j = 0; j < 8; j++) @(negedge clk);
    n_cmp++;
    if ({anodo, catodo} !== {4'hE, 8'h0D}) begin
      n_bad++;
      $display("FAIL idle_load_show: got %h/%h want e/0d", anodo, catodo);
    end
  endtask

  task automatic test_disable;
    do_reset(1'b1);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      n_cmp++;
      if (k <= 20) begin
        if ({anodo, catodo, digito} !== {exp_an(k), exp_cat(k, ZEROS), exp_dig(k)}) begin
          n_bad++;
          $display("FAIL disable_pre k=%0d: got %h/%h/%0d want %h/%h/%0d", k, anodo, catodo,
                   digito, exp_an(k), exp_cat(k, ZEROS), exp_dig(k));
        end
      end else if ({anodo, catodo, digito} !== {4'hF, 8'hFF, 2'd0}) begin
        n_bad++;
        $display("FAIL disable_idle k=%0d: got %h/%h/%0d want f/ff/0", k, anodo, catodo, digito);
      end
      if (k == 20) enable = 1'b0;
      if (k == 24) enable = 1'b1;
    end
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({anodo, catodo, digito} !== {exp_an(j), exp_cat(j, ZEROS), exp_dig(j)}) begin
        n_bad++;
        $display("FAIL disable_restart j=%0d: got %h/%h/%0d want %h/%h/%0d", j, anodo, catodo,
                 digito, exp_an(j), exp_cat(j, ZEROS), exp_dig(j));
      end
    end
  endtask

  task automatic test_blank0;
    logic [3:0] ea;
    do_reset(1'b1);
    for (int k = 0; k < 32; k++) begin
      @(negedge clk);
      ea = ~(4'b0001 << ((k / 8) % 4));
      n_cmp++;
      if ({anodo0, catodo0, digito0, listo0} !== {ea, 8'h03, exp_dig(k), 1'b0}) begin
        n_bad++;
        $display("FAIL blank0 k=%0d: got %h/%h/%0d/%b want %h/03/%0d/0", k, anodo0, catodo0,
                 digito0, listo0, ea, exp_dig(k));
      end
      n_cmp++;
      if ($countones(~anodo0) > 1 || $countones(~anodo) > 1) begin
        n_bad++;
        $display("FAIL blank0_onehot k=%0d: got %b/%b want at most one 0", k, anodo0, anodo);
      end
    end
  endtask

  task automatic test_reset_mid;
    do_reset(1'b1);
    for (int k = 0; k < 14; k++) begin
      @(negedge clk);
      if (k == 3) begin
        cargar = 1'b1;
        catodo1 = 8'h9F; catodo2 = 8'h25; catodo3 = 8'h99; catodo4 = 8'h49;
      end
      if (k == 4) cargar = 1'b0;
      if (k == 12) reset = 1'b1;
      if (k == 13) begin
        n_cmp++;
        if ({anodo, catodo, digito, listo} !== {4'hF, 8'hFF, 2'd0, 1'b0}) begin
          n_bad++;
          $display("FAIL reset_mid: got %h/%h/%0d/%b want f/ff/0/0", anodo, catodo, digito,
                   listo);
        end
        reset = 1'b0;
      end
    end
    for (int j = 0; j < 64; j++) begin
      @(negedge clk);
      n_cmp++;
      if ({anodo, catodo, digito, listo} !== {exp_an(j), exp_cat(j, ZEROS), exp_dig(j), 1'b0})
      begin
        n_bad++;
        $display("FAIL reset_mid_after j=%0d: got %h/%h/%0d/%b want %h/%h/%0d/0", j, anodo,
                 catodo, digito, listo, exp_an(j), exp_cat(j, ZEROS), exp_dig(j));
      end
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; cargar = 1'b0;
    catodo1 = 8'h03; catodo2 = 8'h03; catodo3 = 8'h03; catodo4 = 8'h03;
    test_reset();
    test_load();
    test_double_load();
    test_back_to_back();
    test_idle_load();
    test_disable();
    test_blank0();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
